// File: rtl/cmd_cntrl.sv
// Follower mission sequencer: consumes UART commands and barcode station IDs,
// tracks transit toward a destination, gates motion on OK2Move and drives the piezo.
module cmd_cntrl #(
  parameter int BUZZ_HALF = 6250,
  parameter int ID_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       in_transit,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n
);

  typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} state_t;

  localparam logic [1:0]  OP_STOP = 2'b00;
  localparam logic [1:0]  OP_GO   = 2'b01;
  localparam logic [13:0] BUZZ_TC = 14'(BUZZ_HALF - 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] dest_id_q, dest_id_d;
  logic            in_transit_q, in_transit_d;
  logic            go_q, go_d;
  logic            buzz_q, buzz_d;
  logic            buzz_n_q, buzz_n_d;
  logic [13:0]     buzz_cnt_q, buzz_cnt_d;
  logic            buzz_en_s;

  // Next-state and consume pulses; a pending command always beats a pending ID.
  always_comb begin
    state_d     = state_q;
    dest_id_d   = dest_id_q;
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    if (!rst_n) begin
      state_d   = IDLE;
      dest_id_d = '0;
    end else if (cmd_rdy) begin
      clr_cmd_rdy = 1'b1;
      case (cmd[7:6])
        OP_GO: begin
          dest_id_d = cmd[ID_W-1:0];
          state_d   = MOVING;
        end
        OP_STOP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end else if (ID_vld) begin
      clr_ID_vld = 1'b1;
      if ((state_q == MOVING) && (ID[7:ID_W] == '0) && (ID[ID_W-1:0] == dest_id_q)) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign buzz_en_s = in_transit_q & ~OK2Move;

  // Motion gate and piezo square wave; both drives idle low when not blocked.
  always_comb begin
    in_transit_d = (state_d == MOVING);
    go_d         = in_transit_q & OK2Move;
    buzz_cnt_d   = buzz_cnt_q;
    buzz_d       = buzz_q;
    buzz_n_d     = buzz_n_q;
    if (buzz_en_s) begin
      if (buzz_cnt_q == BUZZ_TC) begin
        buzz_cnt_d = 14'd0;
        buzz_d     = ~buzz_q;
      end else begin
        buzz_cnt_d = buzz_cnt_q + 14'd1;
        buzz_d     = buzz_q;
      end
      buzz_n_d = ~buzz_d;
    end else begin
      buzz_cnt_d = 14'd0;
      buzz_d     = 1'b0;
      buzz_n_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dest_id_q    <= '0;
      in_transit_q <= 1'b0;
      go_q         <= 1'b0;
      buzz_q       <= 1'b0;
      buzz_n_q     <= 1'b0;
      buzz_cnt_q   <= 14'd0;
    end else begin
      state_q      <= state_d;
      dest_id_q    <= dest_id_d;
      in_transit_q <= in_transit_d;
      go_q         <= go_d;
      buzz_q       <= buzz_d;
      buzz_n_q     <= buzz_n_d;
      buzz_cnt_q   <= buzz_cnt_d;
    end
  end

  assign in_transit = in_transit_q;
  assign go         = go_q;
  assign buzz       = buzz_q;
  assign buzz_n     = buzz_n_q;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Bench for cmd_cntrl: directed scenarios plus random traffic, checked each
// cycle against a behavioural model of the mission rules.
module tb_cmd_cntrl;

  localparam int BUZZ_HALF = 6250;

  logic       clk;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] id_b;
  logic       id_vld;
  logic       clr_id_vld;
  logic       ok2move;
  logic       in_transit;
  logic       go;
  logic       buzz;
  logic       buzz_n;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_moving;
  bit [5:0] m_dest;
  bit       m_go;
  int       m_en_cycles;
  bit       m_buzz;
  bit       m_buzz_n;

  cmd_cntrl #(.BUZZ_HALF(BUZZ_HALF), .ID_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID         (id_b),
    .ID_vld     (id_vld),
    .clr_ID_vld (clr_id_vld),
    .OK2Move    (ok2move),
    .in_transit (in_transit),
    .go         (go),
    .buzz       (buzz),
    .buzz_n     (buzz_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check consume pulses before the edge, advance model, check registers after.
  task automatic step();
    bit e_cc;
    bit e_ci;
    bit en;
    e_cc = rst_n && cmd_rdy;
    e_ci = rst_n && !cmd_rdy && id_vld;
    #2;
    check("clr_cmd_rdy", clr_cmd_rdy, e_cc);
    check("clr_ID_vld", clr_id_vld, e_ci);
    @(posedge clk);
    if (!rst_n) begin
      m_moving = 1'b0; m_dest = 6'd0; m_go = 1'b0;
      m_en_cycles = 0; m_buzz = 1'b0; m_buzz_n = 1'b0;
    end else begin
      en   = m_moving && !ok2move;
      m_go = m_moving && ok2move;
      if (en) begin
        m_en_cycles++;
        m_buzz   = ((m_en_cycles / BUZZ_HALF) % 2) == 1;
        m_buzz_n = !m_buzz;
      end else begin
        m_en_cycles = 0; m_buzz = 1'b0; m_buzz_n = 1'b0;
      end
      if (e_cc) begin
        if (cmd[7:6] == 2'b01) begin
          m_moving = 1'b1;
          m_dest   = cmd[5:0];
        end else if (cmd[7:6] == 2'b00) begin
          m_moving = 1'b0;
        end
      end else if (e_ci) begin
        if (m_moving && id_b == {2'b00, m_dest}) m_moving = 1'b0;
      end
    end
    #1;
    check("in_transit", in_transit, m_moving);
    check("go", go, m_go);
    check("buzz", buzz, m_buzz);
    check("buzz_n", buzz_n, m_buzz_n);
    if (e_cc) cmd_rdy = 1'b0;
    if (e_ci) id_vld = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd = c; cmd_rdy = 1'b1;
  endtask

  task automatic send_id(input logic [7:0] v);
    id_b = v; id_vld = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd = 8'h00; cmd_rdy = 1'b0; id_b = 8'h00; id_vld = 1'b0; ok2move = 1'b1;
    m_moving = 1'b0; m_dest = 6'd0; m_go = 1'b0; m_en_cycles = 0; m_buzz = 1'b0; m_buzz_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2);

    // GO to station 1, then a wrong ID and the right ID
    send_cmd(8'h41); run(4);
    send_id(8'h02);  run(3);
    send_id(8'h01);  run(4);

    // Blocked path: buzzer runs for a long stretch, then clears
    send_cmd(8'h41); run(3);
    ok2move = 1'b0;  run(50000);
    ok2move = 1'b1;  run(4);

    // Simultaneous redirect and ID: command first, stale ID misses, new dest hits
    send_cmd(8'h43); send_id(8'h01); run(4);
    send_id(8'h81);  run(2);
    send_id(8'h03);  run(3);

    // STOP while moving, then an illegal opcode in IDLE
    send_cmd(8'h45); run(3);
    send_cmd(8'h00); run(3);
    send_cmd(8'hC5); run(3);

    // Arrival while blocked
    send_cmd(8'h47); run(2);
    ok2move = 1'b0;  run(20);
    send_id(8'h07);  run(4);
    ok2move = 1'b1;  run(2);

    // Reset while buzzing with a command pending
    send_cmd(8'h42); run(2);
    ok2move = 1'b0;  run(7000);
    send_cmd(8'h00);
    rst_n = 1'b0;    run(1);
    rst_n = 1'b1;    run(3);
    ok2move = 1'b1;  run(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (!cmd_rdy && $urandom_range(0, 7) == 0)
        send_cmd({2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))});
      if (!id_vld && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    send_id({2'b00, m_dest});
          2:       send_id({2'b10, m_dest});
          default: send_id(8'($urandom));
        endcase
      end
      if ($urandom_range(0, 15) == 0) ok2move = ~ok2move;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
